// File: rtl/adc_snapshot_pkg.sv
// Shared definitions for the ADC snapshot buffer: FSM encoding, trigger modes, entry layout.
// Pure declarations; no logic or timing of its own.
package adc_snapshot_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ENTRY_W  = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] TRIG_EXT  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;
  localparam logic [1:0] TRIG_NOW  = 2'd3;

  // Entry layout is {adc4, adc3, adc2, adc1}; trig_ch 0 selects adc1.
  function automatic logic signed [SAMPLE_W-1:0] lane_sel(input logic [ENTRY_W-1:0] entry,
                                                          input logic [1:0] ch);
    case (ch)
      2'd0:    lane_sel = entry[15:0];
      2'd1:    lane_sel = entry[31:16];
      2'd2:    lane_sel = entry[47:32];
      default: lane_sel = entry[63:48];
    endcase
  endfunction

endpackage

// File: rtl/snapshot_dpram.sv
// Simple dual-port block RAM: one write port, one registered read port, single clock.
// Read latency 1 cycle; no backpressure, the read register clears on reset.
module snapshot_dpram #(
  parameter int AW = 10,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_snapshot_buf.sv
// Triggered pre/post snapshot of four ADC lanes into a circular RAM, frozen once full.
// State changes one cycle after the qualifying sample; readout 1 cycle; in_valid low stalls everything.
module adc_snapshot_buf
  import adc_snapshot_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         adc1,
  input  logic [15:0]         adc2,
  input  logic [15:0]         adc3,
  input  logic [15:0]         adc4,
  input  logic                in_valid,
  input  logic                arm,
  input  logic                abort,
  input  logic                ext_trig,
  input  logic [1:0]          trig_mode,
  input  logic [1:0]          trig_ch,
  input  logic [15:0]         trig_level,
  input  logic [AW-1:0]       pre_len,
  input  logic [AW-1:0]       rd_addr,
  output logic [ENTRY_W-1:0]  rd_data,
  output logic [2:0]          state,
  output logic                done,
  output logic [AW-1:0]       trig_addr,
  output logic [AW-1:0]       start_addr
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t                    st_q, st_d;
  logic [1:0]                mode_q, ch_q;
  logic signed [15:0]        level_q, prev_q, cur;
  logic                      prev_valid;
  logic [AW-1:0]             pre_q, wptr_q, cnt_q;
  logic [AW:0]               post_q, post_len;
  logic [ENTRY_W-1:0]        entry;
  logic                      capturing, wr_en, hit, arm_ok;

  assign entry     = {adc4, adc3, adc2, adc1};
  assign cur       = lane_sel(entry, ch_q);
  // pre_len is AW bits wide, so it never exceeds DEPTH-1 and needs no further clamping.
  assign post_len  = DEPTH - {1'b0, pre_q};
  assign capturing = (st_q == ST_FILL) || (st_q == ST_ARMED) || (st_q == ST_POST);
  assign wr_en     = in_valid && capturing;
  assign arm_ok    = arm && !abort && ((st_q == ST_IDLE) || (st_q == ST_DONE));

  assign state = st_q;
  assign done  = (st_q == ST_DONE);

  always_comb begin
    hit = 1'b0;
    case (mode_q)
      TRIG_EXT:  hit = ext_trig;
      TRIG_RISE: hit = prev_valid && (prev_q < level_q) && (cur >= level_q);
      TRIG_FALL: hit = prev_valid && (prev_q > level_q) && (cur <= level_q);
      default:   hit = 1'b1;
    endcase
  end

  always_comb begin
    st_d = st_q;
    if (abort) begin
      st_d = ST_IDLE;
    end else begin
      case (st_q)
        ST_IDLE, ST_DONE:
          if (arm) st_d = (pre_len != '0) ? ST_FILL : ST_ARMED;
        ST_FILL:
          if (in_valid && (cnt_q + 1'b1 == pre_q)) st_d = ST_ARMED;
        ST_ARMED:
          if (in_valid && hit) st_d = (post_len == (AW+1)'(1)) ? ST_DONE : ST_POST;
        ST_POST:
          if (in_valid && (post_q + 1'b1 == post_len)) st_d = ST_DONE;
        default:
          st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= ST_IDLE;
      mode_q     <= TRIG_EXT;
      ch_q       <= '0;
      level_q    <= '0;
      pre_q      <= '0;
      wptr_q     <= '0;
      cnt_q      <= '0;
      post_q     <= '0;
      prev_q     <= '0;
      prev_valid <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else begin
      st_q <= st_d;
      if (arm_ok) begin
        mode_q     <= trig_mode;
        ch_q       <= trig_ch;
        level_q    <= trig_level;
        pre_q      <= pre_len;
        wptr_q     <= '0;
        cnt_q      <= '0;
        prev_valid <= 1'b0;
      end
      if (wr_en) begin
        wptr_q     <= wptr_q + 1'b1;
        prev_q     <= cur;
        prev_valid <= 1'b1;
        if (st_q == ST_FILL) cnt_q <= cnt_q + 1'b1;
        if (st_q == ST_POST) post_q <= post_q + 1'b1;
        // The trigger sample is post sample 1 and lands at the current write pointer.
        if (st_q == ST_ARMED && hit && !abort) begin
          trig_addr  <= wptr_q;
          start_addr <= wptr_q - pre_q;
          post_q     <= (AW+1)'(1);
        end
      end
    end
  end

  snapshot_dpram #(.AW(AW), .DW(ENTRY_W)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wptr_q),
    .wr_data (entry),
    .rd_addr (start_addr + rd_addr),
    .rd_data (rd_data)
  );

endmodule
